// File: rtl/reset_sequencer.sv
// Fabric reset sequencer: waits for stable PLL lock / init / board reset,
// then releases downstream reset domains in order, one every STAGE_DELAY.
module reset_sequencer #(
  parameter int NUM_STAGES    = 4,
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGE_DELAY   = 16,
  parameter int HOLD_CYCLES   = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pll_lock,
  input  logic                  init_done,
  input  logic                  ext_reset_n,
  input  logic                  sw_reset_req,
  output logic [NUM_STAGES-1:0] stage_reset_n,
  output logic                  seq_done,
  output logic [2:0]            seq_state,
  output logic [7:0]            relock_count
);

  localparam int MAX_A = (STABLE_CYCLES > STAGE_DELAY) ?
                         STABLE_CYCLES : STAGE_DELAY;
  localparam int MAX_C = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int CW    = $clog2(MAX_C) + 1;
  localparam int IW    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [2:0] {
    WAIT_READY = 3'd0,
    STABLE     = 3'd1,
    RELEASE    = 3'd2,
    RUN        = 3'd3,
    FAULT      = 3'd4
  } state_t;

  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [IW-1:0]         idx, idx_d;
  logic [NUM_STAGES-1:0] stage_d;
  logic [2:0]            sync1, sync2;
  logic                  ready;
  logic                  fault;
  logic                  relock_inc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {pll_lock, init_done, ext_reset_n};
      sync2 <= sync1;
    end
  end

  assign ready = &sync2;
  assign fault = !ready || sw_reset_req;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    idx_d      = idx;
    relock_inc = 1'b0;
    unique case (state)
      WAIT_READY: begin
        if (ready && !sw_reset_req) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (fault) begin
          state_d = WAIT_READY;
          cnt_d   = '0;
        end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      RELEASE: begin
        if (fault) begin
          state_d = FAULT;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (idx == IW'(NUM_STAGES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt == CW'(STAGE_DELAY - 1)) begin
          idx_d = idx + IW'(1);
          cnt_d = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      RUN: begin
        if (fault) begin
          state_d    = FAULT;
          cnt_d      = '0;
          idx_d      = '0;
          relock_inc = 1'b1;
        end
      end
      FAULT: begin
        if (cnt == CW'(HOLD_CYCLES - 1)) begin
          state_d = WAIT_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = WAIT_READY;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so they change with the state flop
  always_comb begin
    stage_d = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_d[i] = (state_d == RUN) ||
                   ((state_d == RELEASE) && (IW'(i) <= idx_d));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= WAIT_READY;
      cnt           <= '0;
      idx           <= '0;
      stage_reset_n <= '0;
      seq_done      <= 1'b0;
      relock_count  <= '0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      idx           <= idx_d;
      stage_reset_n <= stage_d;
      seq_done      <= (state_d == RUN);
      if (relock_inc && (relock_count != 8'hFF))
        relock_count <= relock_count + 8'd1;
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default-sized instance for timing,
// small instance for fault counting and saturation.
module tb_reset_sequencer;

  logic       clock;
  logic       reset_n, pll_lock, init_done, ext_reset_n, sw_reset_req;
  logic [3:0] stage;
  logic       done;
  logic [2:0] st;
  logic [7:0] relock;

  logic       r1, pl1, id1, ex1, sw1;
  logic [1:0] stage1;
  logic       done1;
  logic [2:0] st1;
  logic [7:0] relock1;

  int n_run;
  int n_fail;

  reset_sequencer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pll_lock      (pll_lock),
    .init_done     (init_done),
    .ext_reset_n   (ext_reset_n),
    .sw_reset_req  (sw_reset_req),
    .stage_reset_n (stage),
    .seq_done      (done),
    .seq_state     (st),
    .relock_count  (relock)
  );

  reset_sequencer #(
    .NUM_STAGES    (2),
    .STABLE_CYCLES (2),
    .STAGE_DELAY   (1),
    .HOLD_CYCLES   (1)
  ) dut_small (
    .clock         (clock),
    .reset_n       (r1),
    .pll_lock      (pl1),
    .init_done     (id1),
    .ext_reset_n   (ex1),
    .sw_reset_req  (sw1),
    .stage_reset_n (stage1),
    .seq_done      (done1),
    .seq_state     (st1),
    .relock_count  (relock1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Ends in the first RELEASE cycle; call right after the WAIT_READY entry
  task automatic seq_to_rel(input string tag);
    tick(1);
    chk({tag, "_stable"}, 32'(st), 32'd1);
    tick(1023);
    chk({tag, "_stable_end"}, 32'(st), 32'd1);
    chk({tag, "_held"}, 32'(stage), 32'h0);
    tick(1);
    chk({tag, "_rel"}, 32'(st), 32'd2);
    chk({tag, "_bit0"}, 32'(stage), 32'h1);
  endtask

  task automatic rel_to_run(input string tag);
    tick(15);
    chk({tag, "_b1_early"}, 32'(stage), 32'h1);
    tick(1);
    chk({tag, "_b1"}, 32'(stage), 32'h3);
    tick(16);
    chk({tag, "_b2"}, 32'(stage), 32'h7);
    tick(16);
    chk({tag, "_b3"}, 32'(stage), 32'hF);
    chk({tag, "_done_early"}, 32'(done), 32'd0);
    tick(1);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_run"}, 32'(st), 32'd3);
  endtask

  task automatic wait_run1(input string tag);
    int n;
    n = 0;
    while (st1 != 3'd3 && n < 100) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(st1), 32'd3);
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    reset_n = 1'b0;
    pll_lock = 1'b0;
    init_done = 1'b0;
    ext_reset_n = 1'b0;
    sw_reset_req = 1'b0;
    r1 = 1'b0;
    pl1 = 1'b1;
    id1 = 1'b1;
    ex1 = 1'b1;
    sw1 = 1'b0;
    #3;
    chk("rst_stage", 32'(stage), 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_relock", 32'(relock), 32'd0);

    // Power-up
    tick(1);
    reset_n = 1'b1;
    pll_lock = 1'b1;
    init_done = 1'b1;
    ext_reset_n = 1'b1;
    tick(1026);
    chk("pu_stable", 32'(st), 32'd1);
    chk("pu_held", 32'(stage), 32'h0);
    tick(1);
    chk("pu_rel", 32'(st), 32'd2);
    chk("pu_bit0", 32'(stage), 32'h1);
    rel_to_run("pu");

    // Lock loss in RUN
    pll_lock = 1'b0;
    tick(2);
    chk("ll_pre", 32'(stage), 32'hF);
    tick(1);
    chk("ll_stage", 32'(stage), 32'h0);
    chk("ll_state", 32'(st), 32'd4);
    chk("ll_done", 32'(done), 32'd0);
    chk("ll_relock", 32'(relock), 32'd1);
    pll_lock = 1'b1;
    tick(63);
    chk("ll_hold", 32'(st), 32'd4);
    tick(1);
    chk("ll_wait", 32'(st), 32'd0);
    seq_to_rel("ll");
    rel_to_run("ll");

    // Software request in RUN, second pulse in FAULT
    sw_reset_req = 1'b1;
    tick(1);
    sw_reset_req = 1'b0;
    chk("sw_state", 32'(st), 32'd4);
    chk("sw_stage", 32'(stage), 32'h0);
    chk("sw_relock", 32'(relock), 32'd2);
    tick(10);
    sw_reset_req = 1'b1;
    tick(1);
    sw_reset_req = 1'b0;
    tick(52);
    chk("sw_hold", 32'(st), 32'd4);
    tick(1);
    chk("sw_wait", 32'(st), 32'd0);
    chk("sw_relock2", 32'(relock), 32'd2);

    // One-cycle lock glitch at STABLE count 500
    tick(1);
    chk("gl_stable", 32'(st), 32'd1);
    tick(500);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    chk("gl_pre", 32'(st), 32'd1);
    tick(1);
    chk("gl_wait", 32'(st), 32'd0);
    chk("gl_stage", 32'(stage), 32'h0);
    seq_to_rel("gl");
    rel_to_run("gl");

    // Fault mid-RELEASE
    sw_reset_req = 1'b1;
    tick(1);
    sw_reset_req = 1'b0;
    chk("mr_relock_a", 32'(relock), 32'd3);
    tick(64);
    chk("mr_wait", 32'(st), 32'd0);
    seq_to_rel("mr");
    tick(16);
    chk("mr_b1", 32'(stage), 32'h3);
    ext_reset_n = 1'b0;
    tick(2);
    chk("mr_pre", 32'(stage), 32'h3);
    tick(1);
    chk("mr_stage", 32'(stage), 32'h0);
    chk("mr_state", 32'(st), 32'd4);
    chk("mr_relock", 32'(relock), 32'd3);
    ext_reset_n = 1'b1;
    tick(64);
    chk("mr_wait2", 32'(st), 32'd0);

    // Async reset mid-RELEASE, no clock edge in between
    seq_to_rel("ar");
    tick(20);
    chk("ar_b1", 32'(stage), 32'h3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_stage", 32'(stage), 32'h0);
    chk("ar_state", 32'(st), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_relock", 32'(relock), 32'd0);

    // Small instance: simultaneous ready drop and sw request
    tick(1);
    r1 = 1'b1;
    wait_run1("sm_run0");
    chk("sm_stage", 32'(stage1), 32'h3);
    pl1 = 1'b0;
    tick(2);
    sw1 = 1'b1;
    tick(1);
    sw1 = 1'b0;
    chk("sm_fault", 32'(st1), 32'd4);
    chk("sm_relock", 32'(relock1), 32'd1);
    tick(5);
    chk("sm_wait", 32'(st1), 32'd0);
    chk("sm_relock_b", 32'(relock1), 32'd1);
    pl1 = 1'b1;

    // Saturation: 299 more RUN faults
    for (int i = 0; i < 299; i++) begin
      wait_run1("sat_run");
      sw1 = 1'b1;
      tick(1);
      sw1 = 1'b0;
      if (i == 198)
        chk("sat_200", 32'(relock1), 32'd200);
    end
    chk("sat_255", 32'(relock1), 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
